// File: rtl/thresh_pkg.sv
// Shared definitions for the threshold monitor: FSM state encoding and
// the legal range of the debounce length.
package thresh_pkg;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    localparam int DEBOUNCE_MIN = 1;
    localparam int DEBOUNCE_MAX = 15;

endpackage

// File: rtl/q4.sv
// 4-bit unsigned magnitude comparator: g when x>y, l when x<y, e when x==y.
module q4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       g,
    output logic       l,
    output logic       e
);

    // Purely combinational compare; exactly one of g/l/e is high.
    always_comb begin
        g = (x > y);
        l = (x < y);
        e = (x == y);
    end

endmodule

// File: rtl/thresh_monitor.sv
// Debounced threshold monitor. Consumes the q4 compare of sample vs thr,
// runs a two-state LOW/HIGH FSM with a shared debounce counter, emits
// registered rise/fall pulses and keeps a saturating count of rises.
module thresh_monitor
    import thresh_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       sample,
    input  logic [3:0]       thr,
    input  logic             clr,
    output logic             above,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] evt_count,
    output logic             sat
);

    // A transition fires when the counter already holds DEBOUNCE-1 and one
    // more qualifying sample arrives, i.e. the increment would reach DEBOUNCE.
    localparam logic [3:0]       DBC_LAST = 4'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic       gt;
    logic       lt;
    logic       eq;
    state_t     state;
    logic [3:0] dbc;
    logic       qualify;
    logic       hit;
    logic       rise_evt;
    logic       fall_evt;

    q4 u_cmp (
        .x (sample),
        .y (thr),
        .g (gt),
        .l (lt),
        .e (eq)
    );

    // Decide whether this valid sample qualifies for the current state and
    // whether it completes the debounce run (eq is the hysteresis band).
    always_comb begin
        qualify  = 1'b0;
        hit      = 1'b0;
        rise_evt = 1'b0;
        fall_evt = 1'b0;
        if (in_valid) begin
            qualify = (state == ST_LOW) ? gt : lt;
            hit     = qualify && (dbc == DBC_LAST);
        end
        rise_evt = hit && (state == ST_LOW);
        fall_evt = hit && (state == ST_HIGH);
    end

    // FSM, debounce counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOW;
            dbc   <= 4'd0;
            above <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= rise_evt;
            fall <= fall_evt;
            if (in_valid) begin
                if (hit) begin
                    state <= (state == ST_LOW) ? ST_HIGH : ST_LOW;
                    above <= (state == ST_LOW);
                    dbc   <= 4'd0;
                end else if (qualify) begin
                    dbc <= dbc + 4'd1;
                end else if (!eq) begin
                    dbc <= 4'd0;
                end
            end
        end
    end

    // Saturating rise-event counter with sticky overflow flag; clr wins over
    // a simultaneous rise but never disturbs the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_count <= '0;
            sat       <= 1'b0;
        end else if (clr) begin
            evt_count <= '0;
            sat       <= 1'b0;
        end else if (rise_evt) begin
            if (evt_count == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                evt_count <= evt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_thresh_monitor.sv
// Scoreboard bench for thresh_monitor. Three instances: the default build,
// a 2-bit counter build and a DEBOUNCE=1 build. Stimulus pushes the
// hand-computed expected outputs; a monitor pops and compares after each edge.
module tb_thresh_monitor;

    logic       clk;
    logic       tb_rst_n [3];
    logic       tb_valid [3];
    logic [3:0] tb_sample[3];
    logic [3:0] tb_thr   [3];
    logic       tb_clr   [3];

    logic       above0, rise0, fall0, sat0;
    logic [7:0] cnt0;
    logic       above1, rise1, fall1, sat1;
    logic [1:0] cnt1;
    logic       above2, rise2, fall2, sat2;
    logic [7:0] cnt2;

    typedef struct packed {
        logic [1:0]  dut;
        logic [11:0] snap;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    thresh_monitor #(.DEBOUNCE(3), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(tb_rst_n[0]), .in_valid(tb_valid[0]),
        .sample(tb_sample[0]), .thr(tb_thr[0]), .clr(tb_clr[0]),
        .above(above0), .rise(rise0), .fall(fall0),
        .evt_count(cnt0), .sat(sat0)
    );

    thresh_monitor #(.DEBOUNCE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(tb_rst_n[1]), .in_valid(tb_valid[1]),
        .sample(tb_sample[1]), .thr(tb_thr[1]), .clr(tb_clr[1]),
        .above(above1), .rise(rise1), .fall(fall1),
        .evt_count(cnt1), .sat(sat1)
    );

    thresh_monitor #(.DEBOUNCE(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(tb_rst_n[2]), .in_valid(tb_valid[2]),
        .sample(tb_sample[2]), .thr(tb_thr[2]), .clr(tb_clr[2]),
        .above(above2), .rise(rise2), .fall(fall2),
        .evt_count(cnt2), .sat(sat2)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Snapshot layout: {above, rise, fall, sat, evt_count zero-extended}.
    function automatic logic [11:0] snapOf(input int d);
        case (d)
            0:       return {above0, rise0, fall0, sat0, cnt0};
            1:       return {above1, rise1, fall1, sat1, 6'd0, cnt1};
            default: return {above2, rise2, fall2, sat2, cnt2};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] act,
                               input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got above=%b rise=%b fall=%b sat=%b cnt=%0d, expected above=%b rise=%b fall=%b sat=%b cnt=%0d",
                     name, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // One cycle of stimulus on DUT d (others idle) plus the expected
    // outputs after the following rising edge.
    task automatic applyStimulus(input int d, input logic rst, input logic v,
                                 input logic [3:0] s, input logic [3:0] t,
                                 input logic c, input logic ea, input logic er,
                                 input logic ef, input logic [7:0] ec,
                                 input logic es, input string name);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tb_rst_n[i] = 1'b1;
            tb_valid[i] = 1'b0;
            tb_clr[i]   = 1'b0;
        end
        tb_rst_n[d]  = rst;
        tb_valid[d]  = v;
        tb_sample[d] = s;
        tb_thr[d]    = t;
        tb_clr[d]    = c;
        e.dut  = 2'(d);
        e.snap = {ea, er, ef, es, ec};
        sb_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: every output snapshot after an edge with pending expectation.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n = name_q.pop_front();
                checkOutput(n, snapOf(int'(e.dut)), e.snap);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            tb_rst_n[i]  = 1'b0;
            tb_valid[i]  = 1'b0;
            tb_sample[i] = 4'd0;
            tb_thr[i]    = 4'd0;
            tb_clr[i]    = 1'b0;
        end
        repeat (2) @(posedge clk);

        // Default build: basic rise, thr=8
        applyStimulus(0, 0, 1, 9, 8, 0, 0,0,0, 0,0, "d0_reset");
        applyStimulus(0, 1, 1, 9, 8, 0, 0,0,0, 0,0, "d0_gt1");
        applyStimulus(0, 1, 1, 9, 8, 0, 0,0,0, 0,0, "d0_gt2");
        applyStimulus(0, 1, 1, 9, 8, 0, 1,1,0, 1,0, "d0_rise");
        applyStimulus(0, 1, 0, 9, 8, 0, 1,0,0, 1,0, "d0_rise_one_cycle");
        // HIGH, eq holds dbc: 7,8,7,7
        applyStimulus(0, 1, 1, 7, 8, 0, 1,0,0, 1,0, "d0_lt1");
        applyStimulus(0, 1, 1, 8, 8, 0, 1,0,0, 1,0, "d0_eq_hold");
        applyStimulus(0, 1, 1, 7, 8, 0, 1,0,0, 1,0, "d0_lt2");
        applyStimulus(0, 1, 1, 7, 8, 0, 0,0,1, 1,0, "d0_fall");
        applyStimulus(0, 1, 0, 7, 8, 0, 0,0,0, 1,0, "d0_fall_one_cycle");
        // LOW, thr=5: lt clears, invalid cycles hold
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 1,0, "d0_t3_gt");
        applyStimulus(0, 1, 0, 6, 5, 0, 0,0,0, 1,0, "d0_t3_inv_gt");
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 1,0, "d0_t3_gt2");
        applyStimulus(0, 1, 1, 3, 5, 0, 0,0,0, 1,0, "d0_t3_lt_clear");
        applyStimulus(0, 1, 0, 3, 5, 0, 0,0,0, 1,0, "d0_t3_inv_lt");
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 1,0, "d0_t3_gt_a");
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 1,0, "d0_t3_gt_b");
        applyStimulus(0, 1, 0, 3, 5, 0, 0,0,0, 1,0, "d0_t3_inv_lt2");
        applyStimulus(0, 1, 1, 6, 5, 0, 1,1,0, 2,0, "d0_t3_rise");
        applyStimulus(0, 1, 0, 6, 5, 0, 1,0,0, 2,0, "d0_t3_idle");
        // Back to LOW
        applyStimulus(0, 1, 1, 3, 5, 0, 1,0,0, 2,0, "d0_lt_a");
        applyStimulus(0, 1, 1, 3, 5, 0, 1,0,0, 2,0, "d0_lt_b");
        applyStimulus(0, 1, 1, 3, 5, 0, 0,0,1, 2,0, "d0_fall2");
        // Reset mid-debounce discards partial count
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 2,0, "d0_pre_rst_a");
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 2,0, "d0_pre_rst_b");
        applyStimulus(0, 0, 1, 6, 5, 0, 0,0,0, 0,0, "d0_mid_reset");
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 0,0, "d0_post_rst_1");
        applyStimulus(0, 1, 1, 6, 5, 0, 0,0,0, 0,0, "d0_post_rst_2");
        applyStimulus(0, 1, 1, 6, 5, 0, 1,1,0, 1,0, "d0_post_rst_rise");
        // Threshold change keeps dbc
        applyStimulus(0, 1, 1, 4, 5, 0, 1,0,0, 1,0, "d0_thr_lt1");
        applyStimulus(0, 1, 1, 6, 7, 0, 1,0,0, 1,0, "d0_thr_chg_lt2");
        applyStimulus(0, 1, 1, 6, 7, 0, 0,0,1, 1,0, "d0_thr_chg_fall");

        // CNT_W=2, DEBOUNCE=1: saturation and clr
        applyStimulus(1, 0, 0, 0, 8, 0, 0,0,0, 0,0, "d1_reset");
        applyStimulus(1, 1, 1, 9, 8, 0, 1,1,0, 1,0, "d1_rise1");
        applyStimulus(1, 1, 1, 0, 8, 0, 0,0,1, 1,0, "d1_fall1");
        applyStimulus(1, 1, 1, 9, 8, 0, 1,1,0, 2,0, "d1_rise2");
        applyStimulus(1, 1, 1, 0, 8, 0, 0,0,1, 2,0, "d1_fall2");
        applyStimulus(1, 1, 1, 9, 8, 0, 1,1,0, 3,0, "d1_rise3");
        applyStimulus(1, 1, 1, 0, 8, 0, 0,0,1, 3,0, "d1_fall3");
        applyStimulus(1, 1, 1, 9, 8, 0, 1,1,0, 3,1, "d1_rise4_sat");
        applyStimulus(1, 1, 1, 0, 8, 0, 0,0,1, 3,1, "d1_fall4");
        applyStimulus(1, 1, 0, 0, 8, 0, 0,0,0, 3,1, "d1_sat_sticky");
        applyStimulus(1, 1, 1, 9, 8, 1, 1,1,0, 0,0, "d1_clr_with_rise");
        applyStimulus(1, 1, 1, 0, 8, 0, 0,0,1, 0,0, "d1_fall5");
        applyStimulus(1, 1, 1, 9, 8, 0, 1,1,0, 1,0, "d1_rise_after_clr");

        // DEBOUNCE=1: eq and lt do not qualify in LOW
        applyStimulus(2, 0, 0, 15, 15, 0, 0,0,0, 0,0, "d2_reset");
        applyStimulus(2, 1, 1, 15, 15, 0, 0,0,0, 0,0, "d2_eq_a");
        applyStimulus(2, 1, 1, 15, 15, 0, 0,0,0, 0,0, "d2_eq_b");
        applyStimulus(2, 1, 1, 14, 15, 0, 0,0,0, 0,0, "d2_lt_low");
        applyStimulus(2, 1, 1, 1, 0, 0, 1,1,0, 1,0, "d2_rise");
        applyStimulus(2, 1, 1, 0, 0, 0, 1,0,0, 1,0, "d2_eq_high");

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tb_rst_n[i] = 1'b1;
            tb_valid[i] = 1'b0;
            tb_clr[i]   = 1'b0;
        end
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
